// File: rtl/mist1032isa_uart_receiver.sv
// UART receiver: 2-flop synchronized RXD, 16x oversampled frame FSM, FWFT receive FIFO.
// Defining MIST1032ISA_UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module mist1032isa_uart_receiver #(
  parameter int P_FIFO_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iENA,
  input  logic [15:0] iBAUD_DIV,
  input  logic        iUART_RXD,
  input  logic        iRXD_REQ,
  output logic        oRXD_VALID,
  output logic [7:0]  oRXD_DATA,
  output logic        oFRAMING_ERR,
  output logic        oOVERRUN,
  output logic        oPARITY_ERR
);
  localparam int DEPTH = 1 << P_FIFO_DEPTH_N;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync2_q, prev_q;
  logic [15:0]               div_q, div_d;
  logic [3:0]                os_q, os_d;
  logic [2:0]                bit_q, bit_d;
  logic [7:0]                shift_q, shift_d;
  logic                      push_q, push_d;
  logic [7:0]                push_data_q, push_data_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic [7:0]                mem_q [DEPTH];
  logic [P_FIFO_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [P_FIFO_DEPTH_N:0]   count_q, count_d;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      perr_q, perr_d;
`endif

  logic fall, tick, sample;
  logic fifo_empty, fifo_full, pop, push_ok;

  assign fall   = prev_q & ~sync2_q;
  assign tick   = (div_q == iBAUD_DIV);
  assign sample = tick && (os_q == 4'd7);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    ferr_d      = 1'b0;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    perr_d      = 1'b0;
`endif
    if (state_q != IDLE) begin
      div_d = tick ? 16'd0 : div_q + 16'd1;
      if (tick) os_d = os_q + 4'd1;
    end
    unique case (state_q)
      IDLE: begin
        // Divider and oversample count restart so count 7 lands mid-bit.
        div_d = 16'd0;
        os_d  = 4'd0;
        bit_d = 3'd0;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (iENA && fall) state_d = START;
      end
      START: if (sample) state_d = sync2_q ? IDLE : DATA;
      DATA: if (sample) begin
        shift_d = {sync2_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef MIST1032ISA_UART_RX_PARITY_EN
      PARITY: if (sample) begin
        par_bad_d = ^{shift_q, sync2_q};
        state_d   = STOP;
      end
`endif
      STOP: if (sample) begin
        state_d = IDLE;
        // A bad stop bit takes precedence over a parity mismatch.
        if (!sync2_q) ferr_d = 1'b1;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
        else if (par_bad_q) perr_d = 1'b1;
`endif
        else begin
          push_d      = 1'b1;
          push_data_d = shift_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!iENA) begin
      state_d = IDLE;
      push_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = count_q[P_FIFO_DEPTH_N];
  assign pop        = iRXD_REQ && !fifo_empty;
  assign push_ok    = push_q && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    ovr_d = push_q && fifo_full && !pop;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      div_q       <= 16'd0;
      os_q        <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= iUART_RXD;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      div_q       <= div_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      perr_q      <= perr_d;
`endif
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign oRXD_VALID   = !fifo_empty;
  assign oRXD_DATA    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign oFRAMING_ERR = ferr_q;
  assign oOVERRUN     = ovr_q;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
  assign oPARITY_ERR  = perr_q;
`else
  assign oPARITY_ERR  = 1'b0;
`endif
endmodule

// File: tb/tb_mist1032isa_uart_receiver.sv
// Bench for mist1032isa_uart_receiver: frame-level event model (byte queue keyed by
// absolute cycle) compared every cycle, plus literal checks of directed scenarios.
module tb_mist1032isa_uart_receiver;
  localparam int DEPTH = 4;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        rxd = 1'b1;
  logic        req = 1'b0;
  logic        valid;
  logic [7:0]  data;
  logic        ferr, ovr, perr;

  mist1032isa_uart_receiver #(.P_FIFO_DEPTH_N(2)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iENA(ena), .iBAUD_DIV(baud_div),
    .iUART_RXD(rxd), .iRXD_REQ(req), .oRXD_VALID(valid), .oRXD_DATA(data),
    .oFRAMING_ERR(ferr), .oOVERRUN(ovr), .oPARITY_ERR(perr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int   cyc = 0;
  logic req_s, rst_s;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    req_s <= req;
    rst_s <= rst;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] push_at[int];
  bit         ferr_at[int];
  bit         perr_at[int];
  int  n_checks = 0, n_fail = 0;
  int  ferr_seen = 0, ovr_seen = 0, perr_seen = 0;
  bit  done = 1'b0;
  logic e_ferr, e_perr, e_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A good frame appears in the queue the edge after its stop sample;
  // error pulses are visible right after the stop sample edge.
  initial forever begin
    @(negedge clk);
    if (cyc >= 1 && !done) begin
      e_ferr = 1'b0; e_perr = 1'b0; e_ovr = 1'b0;
      if (rst_s) exp_q.delete();
      else begin
        if (req_s && exp_q.size() != 0) void'(exp_q.pop_front());
        if (push_at.exists(cyc)) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(push_at[cyc]);
          else e_ovr = 1'b1;
        end
        e_ferr = ferr_at.exists(cyc);
        e_perr = perr_at.exists(cyc);
      end
      check("valid", valid, exp_q.size() != 0);
      check("data", data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      check("framing_err", ferr, e_ferr);
      check("overrun", ovr, e_ovr);
      check("parity_err", perr, e_perr);
      if (ferr) ferr_seen++;
      if (ovr)  ovr_seen++;
      if (perr) perr_seen++;
    end
  end

  // pop driver: explicit pops on request, otherwise optional random pops
  int pop_ask = 0, pop_done = 0;
  bit pop_rand = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (pop_ask != pop_done) begin
      req = 1'b1;
      pop_done++;
    end else req = pop_rand && ($urandom_range(0, 31) == 0);
  end

  task automatic pop_one();
    pop_ask++;
    repeat (3) @(negedge clk);
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    int p, bp, s_stop;
    logic [10:0] fr;
    bp = 16 * (int'(baud_div) + 1);
    fr = 11'h7FF;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef MIST1032ISA_UART_RX_PARITY_EN
    fr[9]  = (^b) ^ !par_ok;
    fr[10] = stop_ok;
`else
    fr[9]  = stop_ok;
`endif
    @(posedge clk); #1;
    p = cyc;
    // 2 sync flops + edge detect, then half a bit to the centre of each bit
    s_stop = p + 3 + bp / 2 + bp * STOP_IDX;
    if (!stop_ok) ferr_at[s_stop] = 1'b1;
    else if (!par_ok) perr_at[s_stop] = 1'b1;
    else push_at[s_stop + 1] = b;
    for (int i = 0; i <= STOP_IDX; i++) begin
      rxd = fr[i];
      repeat (bp) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    int bp;
    bp = 16 * (int'(baud_div) + 1);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (bp) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      rxd = b[i];
      repeat (bp) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int f0, o0, p0;
  initial begin
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", valid, 1'b0);
    check("reset_data", data, 8'h00);

    // single byte at 64 clocks per bit
    f0 = ferr_seen;
    send_frame(8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    check("a5_valid", valid, 1'b1);
    check("a5_data", data, 8'hA5);
    check("a5_no_ferr", ferr_seen - f0, 0);
    pop_one();

    // five bytes into a depth-4 FIFO with no pops
    o0 = ovr_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
    @(negedge clk);
    check("ovr_once", ovr_seen - o0, 1);
    for (int i = 1; i <= 4; i++) begin
      check("fifo_order", data, i);
      pop_one();
    end
    check("fifo_drained", valid, 1'b0);

    // bad stop bit
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(4);
    @(negedge clk);
    check("ferr_once", ferr_seen - f0, 1);
    check("ferr_no_push", valid, 1'b0);

    // short glitch, then a good byte
    @(posedge clk); #1 rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(80);
    send_frame(8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    check("glitch_then_5a", data, 8'h5A);
    pop_one();

    // reset after data bit 3 of 0xFF
    send_partial(8'hFF, 4);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1);
    @(negedge clk);
    check("after_reset_data", data, 8'h12);
    pop_one();
    check("after_reset_empty", valid, 1'b0);

    // enable dropped mid-frame; queued byte survives and can be popped
    send_frame(8'h77, 1'b1, 1'b1);
    send_partial(8'h96, 5);
    ena = 1'b0;
    rxd = 1'b1;
    idle(20);
    @(negedge clk);
    check("abort_keep_data", data, 8'h77);
    pop_one();
    check("abort_pop_empty", valid, 1'b0);
    @(posedge clk); #1 ena = 1'b1;
    idle(10);

`ifdef MIST1032ISA_UART_RX_PARITY_EN
    p0 = perr_seen;
    send_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    check("perr_once", perr_seen - p0, 1);
    check("perr_no_push", valid, 1'b0);
`endif

    // randomized frames with random pops and baud divisors
    p0 = perr_seen;
    pop_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      baud_div = 16'($urandom_range(0, 3));
`ifdef MIST1032ISA_UART_RX_PARITY_EN
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0);
`else
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, 1'b1);
`endif
      idle($urandom_range(0, 40));
    end
`ifndef MIST1032ISA_UART_RX_PARITY_EN
    check("parity_tied_low", perr_seen - p0, 0);
`endif
    idle(400);
    pop_rand = 1'b0;
    idle(5);
    @(negedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
